// File: rtl/toggle_encoder_tx.sv
// toggle_encoder_tx
//
// Serialises a parallel word onto one line using toggle (NRZI-style) encoding.
// A 1 bit toggles the line at the start of its bit period; a 0 bit holds it.
// Each frame is PREAMBLE_BITS ones followed by the DATA_W payload bits, LSB first.
// Each bit period lasts CLKS_PER_BIT clock cycles.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   in_valid  in   in_data is offered for transmission
//   in_ready  out  block can accept a word (idle and not in reset)
//   in_data   in   payload word, sent LSB first
//   line      out  toggle-encoded serial output (registered)
//   busy      out  a frame is in progress
//   done      out  one-cycle pulse after the last bit period ends
module toggle_encoder_tx #(
    parameter int DATA_W        = 8,
    parameter int CLKS_PER_BIT  = 4,
    parameter int PREAMBLE_BITS = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              line,
    output logic              busy,
    output logic              done
);

    localparam int N  = PREAMBLE_BITS + DATA_W;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    // Bit index of the first payload bit.
    localparam logic [BW-1:0] PRE_END  = BW'(PREAMBLE_BITS);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic              line_q, line_d;
    logic              done_q, done_d;
    logic [BW-1:0]     bit_next_s;

    assign bit_next_s = bit_q + BW'(1);

    // Next-state logic: frame sequencing, bit timing and line encoding.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        line_d  = line_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Bit 0 starts on the accept edge itself, so its toggle is applied now.
                if (in_valid) begin
                    cyc_d = '0;
                    bit_d = '0;
                    if (PREAMBLE_BITS > 0) begin
                        state_d = ST_PREAMBLE;
                        sr_d    = in_data;
                        line_d  = ~line_q;
                    end else begin
                        state_d = ST_DATA;
                        sr_d    = in_data >> 1;
                        line_d  = line_q ^ in_data[0];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREAMBLE, ST_DATA: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_next_s;
                        // Still inside the preamble: the bit is always 1.
                        if ((state_q == ST_PREAMBLE) && (bit_next_s != PRE_END)) begin
                            line_d = ~line_q;
                        end else begin
                            state_d = ST_DATA;
                            line_d  = line_q ^ sr_q[0];
                            sr_d    = sr_q >> 1;
                        end
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any frame silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            line_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            line_q  <= line_d;
            done_q  <= done_d;
        end
    end

    assign line     = line_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE);
    assign in_ready = (state_q == ST_IDLE) && !reset;

endmodule
